// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
package seq_det_pkg;

   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_LEN_W   = 4;
   localparam int DEF_CNT_W   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HALT = 2'b10
   } state_e;

   typedef struct packed {
      logic [DEF_MAX_LEN-1:0] pattern;
      logic [DEF_LEN_W-1:0]   len;
      logic                   overlap;
      logic [DEF_CNT_W-1:0]   threshold;
   } cfg_t;

   function automatic logic len_ok(input int len, input int max_len);
      return (len >= 1) && (len <= max_len);
   endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and length-masked comparator.
module seq_match_core #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4
) (
   input  logic               clk,
   input  logic               aresetn,
   input  logic               shift_en,
   input  logic               bit_in,
   input  logic               clear,
   input  logic               clear_fill,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   output logic               hit
);
   logic [MAX_LEN-1:0] history, hist_next, mask;
   logic [LEN_W-1:0]   fill, fill_next;

   // hit looks at the history as it will be after this beat's shift
   always_comb begin
      hist_next = {history[MAX_LEN-2:0], bit_in};
      fill_next = (fill >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill + 1'b1;
      mask      = '0;
      for (int i = 0; i < MAX_LEN; i++)
         mask[i] = (i < int'(len));
      hit = shift_en && (fill_next >= len) &&
            ((hist_next & mask) == (pattern & mask));
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         history <= '0;
         fill    <= '0;
      end else if (clear) begin
         history <= '0;
         fill    <= '0;
      end else if (shift_en) begin
         history <= hist_next;
         fill    <= clear_fill ? '0 : fill_next;
      end
   end

endmodule

// File: rtl/seq_det_ctrl.sv
// Config handshake, IDLE/RUN/HALT control, saturating match counter and sticky irq.
module seq_det_ctrl
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int LEN_W   = DEF_LEN_W,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               aresetn,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic [CNT_W-1:0]   cfg_threshold,
   output logic               cfg_err,
   input  logic               start,
   input  logic               stop,
   input  logic               bit_valid,
   input  logic               bit_in,
   output logic               match,
   output logic [CNT_W-1:0]   match_count,
   output logic               irq,
   input  logic               irq_clr,
   output logic               busy
);
   state_e             state;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               ovl_q;
   logic [CNT_W-1:0]   thr_q;
   logic               cfg_loaded;
   logic               hit, arm, irq_set;
   logic [CNT_W-1:0]   cnt_next;

   assign cfg_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   // a config beat in the same cycle wins over start
   assign arm       = (state == IDLE) && start && cfg_loaded && !cfg_valid;
   assign cnt_next  = (&match_count) ? match_count : match_count + 1'b1;
   assign irq_set   = (state == RUN) && hit && (thr_q != '0) && (cnt_next == thr_q);

   seq_match_core #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_core (
      .clk        (clk),
      .aresetn    (aresetn),
      .shift_en   ((state == RUN) && bit_valid),
      .bit_in     (bit_in),
      .clear      (arm),
      .clear_fill (hit && !ovl_q),
      .pattern    (pat_q),
      .len        (len_q),
      .hit        (hit)
   );

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state       <= IDLE;
         pat_q       <= '0;
         len_q       <= '0;
         ovl_q       <= 1'b0;
         thr_q       <= '0;
         cfg_loaded  <= 1'b0;
         cfg_err     <= 1'b0;
         match       <= 1'b0;
         match_count <= '0;
         irq         <= 1'b0;
      end else begin
         cfg_err <= 1'b0;
         match   <= 1'b0;
         if (irq_clr)      irq <= 1'b0;
         else if (irq_set) irq <= 1'b1;
         case (state)
            IDLE: begin
               if (cfg_valid) begin
                  if (len_ok(int'(cfg_len), MAX_LEN)) begin
                     pat_q      <= cfg_pattern;
                     len_q      <= cfg_len;
                     ovl_q      <= cfg_overlap;
                     thr_q      <= cfg_threshold;
                     cfg_loaded <= 1'b1;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end else if (arm) begin
                  state       <= RUN;
                  match_count <= '0;
               end
            end
            RUN: begin
               if (hit) begin
                  match       <= 1'b1;
                  match_count <= cnt_next;
               end
               // stop still lets the final match be counted, but never halts
               if (stop)                     state <= IDLE;
               else if (irq_set && !irq_clr) state <= HALT;
            end
            HALT: if (irq_clr) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl with a bit-queue reference model checked every cycle.
module tb_seq_det_ctrl;
   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 8;

   logic               clk = 1'b0;
   logic               aresetn = 1'b0;
   logic               cfg_valid = 1'b0;
   logic               cfg_ready;
   logic [MAX_LEN-1:0] cfg_pattern = '0;
   logic [LEN_W-1:0]   cfg_len = '0;
   logic               cfg_overlap = 1'b0;
   logic [CNT_W-1:0]   cfg_threshold = '0;
   logic               cfg_err;
   logic               start = 1'b0, stop = 1'b0, bit_valid = 1'b0, bit_in = 1'b0;
   logic               match;
   logic [CNT_W-1:0]   match_count;
   logic               irq;
   logic               irq_clr = 1'b0;
   logic               busy;

   int n_vec = 0;
   int n_bad = 0;

   seq_det_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .aresetn(aresetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .cfg_threshold(cfg_threshold), .cfg_err(cfg_err), .start(start), .stop(stop),
      .bit_valid(bit_valid), .bit_in(bit_in), .match(match), .match_count(match_count),
      .irq(irq), .irq_clr(irq_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: remembers the bits seen since arming (or since the last
   // non-overlapping match) and compares the newest len of them to the pattern.
   int  m_st = 0;               // 0 idle, 1 running, 2 halted
   bit  m_loaded = 0, m_err = 0, m_match = 0, m_irq = 0, m_ovl = 0;
   int  m_len = 0, m_thr = 0, m_cnt = 0;
   bit [MAX_LEN-1:0] m_pat = '0;
   bit  q[$];

   always @(posedge clk or negedge aresetn) begin : model
      bit found, reached;
      if (!aresetn) begin
         m_st = 0; m_loaded = 0; m_err = 0; m_match = 0; m_irq = 0;
         m_cnt = 0; m_len = 0; m_thr = 0; m_ovl = 0; m_pat = '0;
         q.delete();
      end else begin
         found = 0; reached = 0;
         m_err = 0; m_match = 0;
         if (m_st == 0) begin
            if (cfg_valid) begin
               if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
                  m_pat = cfg_pattern; m_len = cfg_len; m_ovl = cfg_overlap;
                  m_thr = cfg_threshold; m_loaded = 1;
               end else m_err = 1;
            end else if (start && m_loaded) begin
               m_st = 1; m_cnt = 0; q.delete();
            end
         end else if (m_st == 1) begin
            if (bit_valid) begin
               q.push_back(bit_in);
               if (q.size() > MAX_LEN) void'(q.pop_front());
               if (q.size() >= m_len) begin
                  found = 1;
                  for (int i = 0; i < m_len; i++)
                     if (q[q.size()-1-i] != m_pat[i]) found = 0;
               end
            end
            if (found) begin
               m_match = 1;
               if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
               if (!m_ovl) q.delete();
               reached = (m_thr != 0) && (m_cnt == m_thr);
            end
            if (stop) m_st = 0;
            else if (reached && !irq_clr) m_st = 2;
         end else if (irq_clr) m_st = 0;
         if (irq_clr) m_irq = 0;
         else if (reached) m_irq = 1;
      end
   end

   always @(negedge clk) begin
      chk("cfg_ready", 32'(cfg_ready), 32'(m_st == 0));
      chk("busy", 32'(busy), 32'(m_st != 0));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      chk("match", 32'(match), 32'(m_match));
      chk("match_count", 32'(match_count), 32'(m_cnt));
      chk("irq", 32'(irq), 32'(m_irq));
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                         input logic [7:0] thr);
      cfg_valid = 1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_threshold = thr;
      tick();
      cfg_valid = 0;
   endtask

   task automatic do_start();
      start = 1; tick(); start = 0;
   endtask

   task automatic do_stop();
      stop = 1; tick(); stop = 0;
   endtask

   // Element i is applied on cycle i; hits[i] is the match pulse that follows it.
   task automatic run_bits(input logic [15:0] bits, input logic [15:0] vld,
                           input logic [15:0] stp, input int n, output logic [15:0] hits);
      hits = '0;
      for (int i = 0; i < n; i++) begin
         bit_valid = vld[i]; bit_in = bits[i]; stop = stp[i];
         tick();
         hits[i] = match;
      end
      bit_valid = 0; bit_in = 0; stop = 0;
   endtask

   initial begin : stim
      logic [15:0] h;
      repeat (2) @(posedge clk);
      #1;
      chk("reset cfg_ready", 32'(cfg_ready), 32'd1);
      chk("reset busy", 32'(busy), 32'd0);
      aresetn = 1;
      tick();

      // illegal lengths are rejected and leave the block unconfigured
      do_cfg(8'h05, 4'd0, 1'b1, 8'd0);
      chk("err len0", 32'(cfg_err), 32'd1);
      tick();
      chk("err len0 one-shot", 32'(cfg_err), 32'd0);
      do_cfg(8'h05, 4'(MAX_LEN + 1), 1'b1, 8'd0);
      chk("err len9", 32'(cfg_err), 32'd1);
      do_start();
      chk("start unloaded busy", 32'(busy), 32'd0);

      // overlapping 101
      do_cfg(8'b101, 4'd3, 1'b1, 8'd0);
      chk("legal cfg no err", 32'(cfg_err), 32'd0);
      do_start();
      chk("armed busy", 32'(busy), 32'd1);
      run_bits(16'b10101, 16'h1f, 16'h0, 5, h);
      chk("overlap hits", 32'(h[4:0]), 32'b10100);
      chk("overlap count", 32'(match_count), 32'd2);
      chk("overlap irq", 32'(irq), 32'd0);

      // non-overlapping 101
      do_stop();
      do_cfg(8'b101, 4'd3, 1'b0, 8'd0);
      do_start();
      chk("fresh count", 32'(match_count), 32'd0);
      run_bits(16'b10101, 16'h1f, 16'h0, 5, h);
      chk("nonovl hits", 32'(h[4:0]), 32'b00100);
      chk("nonovl count", 32'(match_count), 32'd1);

      // threshold 3 on pattern 11 halts after the fourth bit
      do_stop();
      do_cfg(8'b11, 4'd2, 1'b1, 8'd3);
      do_start();
      run_bits(16'b11111, 16'h1f, 16'h0, 5, h);
      chk("thr hits", 32'(h[4:0]), 32'b01110);
      chk("thr count", 32'(match_count), 32'd3);
      chk("thr irq", 32'(irq), 32'd1);
      chk("halt busy", 32'(busy), 32'd1);
      chk("halt cfg_ready", 32'(cfg_ready), 32'd0);
      irq_clr = 1; tick(); irq_clr = 0;
      chk("clr irq", 32'(irq), 32'd0);
      chk("clr busy", 32'(busy), 32'd0);
      chk("clr cfg_ready", 32'(cfg_ready), 32'd1);

      // gaps between qualified bits
      do_cfg(8'b101, 4'd3, 1'b1, 8'd0);
      do_start();
      run_bits(16'b100001, 16'b100101, 16'h0, 6, h);
      chk("gap hits", 32'(h[5:0]), 32'b100000);

      // stop coinciding with the threshold-reaching match
      do_stop();
      do_cfg(8'b101, 4'd3, 1'b1, 8'd1);
      do_start();
      run_bits(16'b101, 16'b111, 16'b100, 3, h);
      chk("stop hits", 32'(h[2:0]), 32'b100);
      chk("stop count", 32'(match_count), 32'd1);
      chk("stop busy", 32'(busy), 32'd0);
      tick();
      chk("stop count kept", 32'(match_count), 32'd1);

      // asynchronous reset in the middle of a run
      do_cfg(8'b101, 4'd3, 1'b1, 8'd0);
      do_start();
      run_bits(16'b101, 16'b111, 16'h0, 3, h);
      chk("pre-reset count", 32'(match_count), 32'd1);
      #2 aresetn = 0;
      #1;
      chk("arst count", 32'(match_count), 32'd0);
      chk("arst irq", 32'(irq), 32'd0);
      chk("arst busy", 32'(busy), 32'd0);
      chk("arst cfg_ready", 32'(cfg_ready), 32'd1);
      tick();
      aresetn = 1;
      tick();
      do_start();
      chk("post-reset start busy", 32'(busy), 32'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
